// File: rtl/dmem_access_unit.sv
// dmem_access_unit: formats M-stage loads/stores for a synchronous-read data RAM.
// Stores and misalign detection are combinational in the request cycle. A load result
// appears the cycle after its request, combinational from ram_dout and the pend_* regs.
// Backpressure: none. The unit assumes the pipeline never stalls between request and result.
//
// Ports:
//   clk, rst           clock, async active-low reset
//   mem_r_m, mem_w_m   load / store request (a store wins if both are high)
//   mem_op_m           funct3 access size/sign
//   addr_m, wdata_m    byte address, right-justified store data
//   err_clr            clears the sticky misalign flag
//   ram_*              word address, active-low write enable, byte enables, write/read data
//   load_valid_w/_data_w  extended load result, one cycle after the request
//   misalign_m         current request is misaligned (combinational)
//   err_sticky/err_addr   first misaligned address since reset or clear
module dmem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_m,
  input  logic        mem_w_m,
  input  logic [2:0]  mem_op_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic        err_clr,
  output logic [31:0] ram_addr,
  output logic        ram_wen_n,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        load_valid_w,
  output logic [31:0] load_data_w,
  output logic        misalign_m,
  output logic        err_sticky,
  output logic [31:0] err_addr
);

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  logic        r_pend_vld;
  logic [2:0]  r_pend_op;
  logic [1:0]  r_pend_off;
  logic        r_err_sticky;
  logic [31:0] r_err_addr;

  logic        w_is_st;
  logic        w_is_ld;
  logic        w_st_legal;
  logic        w_ld_legal;
  logic        w_legal;
  logic        w_misaligned;
  logic        w_do_st;
  logic        w_do_ld;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // A simultaneous load request is dropped in favour of the store.
  assign w_is_st = mem_w_m;
  assign w_is_ld = mem_r_m & ~mem_w_m;

  // Unsigned variants exist only for loads; as stores they are illegal.
  assign w_st_legal = (mem_op_m == OP_B) || (mem_op_m == OP_H) || (mem_op_m == OP_W);
  assign w_ld_legal = w_st_legal || (mem_op_m == OP_BU) || (mem_op_m == OP_HU);
  assign w_legal    = w_is_st ? w_st_legal : w_ld_legal;

  always_comb begin
    w_misaligned = 1'b0;
    case (mem_op_m)
      OP_H, OP_HU: w_misaligned = addr_m[0];
      OP_W:        w_misaligned = (addr_m[1:0] != 2'b00);
      default:     w_misaligned = 1'b0;
    endcase
  end

  assign misalign_m = (w_is_st | w_is_ld) & w_legal & w_misaligned;
  assign w_do_st    = w_is_st & w_st_legal & ~w_misaligned;
  assign w_do_ld    = w_is_ld & w_ld_legal & ~w_misaligned;

  // Store formatting. Write enable is held off combinationally while in reset.
  assign ram_addr  = {addr_m[31:2], 2'b00};
  assign ram_wen_n = ~(w_do_st & rst);

  always_comb begin
    ram_be  = 4'b0000;
    ram_din = wdata_m;
    if (w_do_st) begin
      case (mem_op_m)
        OP_B: begin
          ram_be  = 4'b0001 << addr_m[1:0];
          ram_din = {4{wdata_m[7:0]}};
        end
        OP_H: begin
          ram_be  = 4'b0011 << addr_m[1:0];
          ram_din = {2{wdata_m[15:0]}};
        end
        default: begin
          ram_be  = 4'b1111;
          ram_din = wdata_m;
        end
      endcase
    end
  end

  // Load tracking across the one-cycle RAM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_vld <= 1'b0;
      r_pend_op  <= 3'b000;
      r_pend_off <= 2'b00;
    end else begin
      r_pend_vld <= w_do_ld;
      if (w_do_ld) begin
        r_pend_op  <= mem_op_m;
        r_pend_off <= addr_m[1:0];
      end
    end
  end

  // Lane extraction from the returned word.
  always_comb begin
    w_byte = ram_dout[7:0];
    case (r_pend_off)
      2'd1:    w_byte = ram_dout[15:8];
      2'd2:    w_byte = ram_dout[23:16];
      2'd3:    w_byte = ram_dout[31:24];
      default: w_byte = ram_dout[7:0];
    endcase
  end

  assign w_half = r_pend_off[1] ? ram_dout[31:16] : ram_dout[15:0];

  always_comb begin
    load_data_w = 32'h0;
    if (r_pend_vld) begin
      case (r_pend_op)
        OP_B:    load_data_w = {{24{w_byte[7]}}, w_byte};
        OP_BU:   load_data_w = {24'h0, w_byte};
        OP_H:    load_data_w = {{16{w_half[15]}}, w_half};
        OP_HU:   load_data_w = {16'h0, w_half};
        OP_W:    load_data_w = ram_dout;
        default: load_data_w = 32'h0;
      endcase
    end
  end

  assign load_valid_w = r_pend_vld;

  // Sticky error: a capture in the same cycle as a clear takes priority,
  // since the clear only applies to errors seen before this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_sticky <= 1'b0;
      r_err_addr   <= 32'h0;
    end else if (misalign_m && (!r_err_sticky || err_clr)) begin
      r_err_sticky <= 1'b1;
      r_err_addr   <= addr_m;
    end else if (err_clr && !misalign_m) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign err_sticky = r_err_sticky;
  assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_r_m;
  logic        mem_w_m;
  logic [2:0]  mem_op_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        err_clr;
  logic [31:0] ram_addr;
  logic        ram_wen_n;
  logic [3:0]  ram_be;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        load_valid_w;
  logic [31:0] load_data_w;
  logic        misalign_m;
  logic        err_sticky;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_errors = 0;

  dmem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r_m      (mem_r_m),
    .mem_w_m      (mem_w_m),
    .mem_op_m     (mem_op_m),
    .addr_m       (addr_m),
    .wdata_m      (wdata_m),
    .err_clr      (err_clr),
    .ram_addr     (ram_addr),
    .ram_wen_n    (ram_wen_n),
    .ram_be       (ram_be),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .load_valid_w (load_valid_w),
    .load_data_w  (load_data_w),
    .misalign_m   (misalign_m),
    .err_sticky   (err_sticky),
    .err_addr     (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then present a request.
  task automatic req(input logic r, input logic w, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] wd, input logic clr,
                     input logic [31:0] dout);
    @(posedge clk);
    #1;
    mem_r_m  = r;
    mem_w_m  = w;
    mem_op_m = op;
    addr_m   = a;
    wdata_m  = wd;
    err_clr  = clr;
    ram_dout = dout;
    #1;
  endtask

  task automatic idle(input logic [31:0] dout);
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, dout);
  endtask

  initial begin
    rst = 1'b0;
    mem_r_m = 1'b0; mem_w_m = 1'b0; mem_op_m = 3'b000;
    addr_m = 32'h0; wdata_m = 32'h0; err_clr = 1'b0; ram_dout = 32'h0;

    // Reset state, with an aligned SW requested to show the write is blocked.
    #2;
    mem_w_m = 1'b1; mem_op_m = 3'b010; addr_m = 32'h40; wdata_m = 32'h1234_5678;
    #1;
    chk("rst_wen_n", {31'h0, ram_wen_n}, 32'h1);
    chk("rst_valid", {31'h0, load_valid_w}, 32'h0);
    chk("rst_data", load_data_w, 32'h0);
    chk("rst_sticky", {31'h0, err_sticky}, 32'h0);
    chk("rst_eaddr", err_addr, 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_wen_n", {31'h0, ram_wen_n}, 32'h1);
    rst = 1'b1;
    mem_w_m = 1'b0;

    // SB 0x103
    req(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AB, 1'b0, 32'h0);
    chk("sb_addr", ram_addr, 32'h100);
    chk("sb_be", {28'h0, ram_be}, 32'h8);
    chk("sb_din", ram_din, 32'hABAB_ABAB);
    chk("sb_wen_n", {31'h0, ram_wen_n}, 32'h0);
    chk("sb_mis", {31'h0, misalign_m}, 32'h0);

    // SH 0x102
    req(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 1'b0, 32'h0);
    chk("sh_be", {28'h0, ram_be}, 32'hC);
    chk("sh_din", ram_din, 32'hBEEF_BEEF);

    // LBU 0x103 then LB 0x103, back to back
    req(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 32'h0);
    chk("lbu_wen_n", {31'h0, ram_wen_n}, 32'h1);
    chk("lbu_be", {28'h0, ram_be}, 32'h0);
    req(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'hAB00_0000);
    chk("lbu_vld", {31'h0, load_valid_w}, 32'h1);
    chk("lbu_data", load_data_w, 32'h0000_00AB);
    // LH 0x202
    req(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 1'b0, 32'hAB00_0000);
    chk("lb_data", load_data_w, 32'hFFFF_FFAB);
    // LHU 0x202
    req(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 1'b0, 32'h8001_1234);
    chk("lh_data", load_data_w, 32'hFFFF_8001);
    // LW 0x200
    req(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 32'h8001_1234);
    chk("lhu_data", load_data_w, 32'h0000_8001);
    // LBU 0x201 (byte lane 1)
    req(1'b1, 1'b0, 3'b100, 32'h201, 32'h0, 1'b0, 32'h8001_1234);
    chk("lw_data", load_data_w, 32'h8001_1234);
    idle(32'h8001_1234);
    chk("lbu1_data", load_data_w, 32'h0000_0012);
    idle(32'h8001_1234);
    chk("idle_vld", {31'h0, load_valid_w}, 32'h0);
    chk("idle_data", load_data_w, 32'h0);

    // Misaligned SW 0x305
    req(1'b0, 1'b1, 3'b010, 32'h305, 32'hDEAD_BEEF, 1'b0, 32'h0);
    chk("sw_mis", {31'h0, misalign_m}, 32'h1);
    chk("sw_mis_wen_n", {31'h0, ram_wen_n}, 32'h1);
    chk("sw_mis_be", {28'h0, ram_be}, 32'h0);
    chk("sw_mis_din", ram_din, 32'hDEAD_BEEF);
    // Misaligned LH 0x401
    req(1'b1, 1'b0, 3'b001, 32'h401, 32'h0, 1'b0, 32'h0);
    chk("err_sticky1", {31'h0, err_sticky}, 32'h1);
    chk("err_addr1", err_addr, 32'h305);
    chk("lh_mis", {31'h0, misalign_m}, 32'h1);
    // err_clr together with misaligned LW 0x502
    req(1'b1, 1'b0, 3'b010, 32'h502, 32'h0, 1'b1, 32'h0);
    chk("lh_mis_novld", {31'h0, load_valid_w}, 32'h0);
    chk("err_addr_kept", err_addr, 32'h305);
    // err_clr alone
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h0);
    chk("clr_cap_sticky", {31'h0, err_sticky}, 32'h1);
    chk("clr_cap_addr", err_addr, 32'h502);
    idle(32'h0);
    chk("clr_sticky", {31'h0, err_sticky}, 32'h0);
    chk("clr_addr_kept", err_addr, 32'h502);

    // Four consecutive LWs
    req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
    req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h1111_0000);
    chk("b2b0_vld", {31'h0, load_valid_w}, 32'h1);
    chk("b2b0_data", load_data_w, 32'h1111_0000);
    req(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'h2222_0004);
    chk("b2b1_vld", {31'h0, load_valid_w}, 32'h1);
    chk("b2b1_data", load_data_w, 32'h2222_0004);
    req(1'b1, 1'b0, 3'b010, 32'hC, 32'h0, 1'b0, 32'h3333_0008);
    chk("b2b2_data", load_data_w, 32'h3333_0008);
    idle(32'h4444_000C);
    chk("b2b3_vld", {31'h0, load_valid_w}, 32'h1);
    chk("b2b3_data", load_data_w, 32'h4444_000C);

    // Load then reset before the result cycle; a store is presented during reset.
    req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h0);
    req(1'b0, 1'b1, 3'b010, 32'h20, 32'h5555_5555, 1'b0, 32'h9999_9999);
    chk("pre_rst_vld", {31'h0, load_valid_w}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", {31'h0, load_valid_w}, 32'h0);
    chk("mid_rst_data", load_data_w, 32'h0);
    chk("mid_rst_wen_n", {31'h0, ram_wen_n}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(32'h0);
    chk("post_rst_vld", {31'h0, load_valid_w}, 32'h0);

    // Load and store together: store wins, load dropped.
    req(1'b1, 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 1'b0, 32'h0);
    chk("rw_wen_n", {31'h0, ram_wen_n}, 32'h0);
    chk("rw_be", {28'h0, ram_be}, 32'hF);
    chk("rw_din", ram_din, 32'hCAFE_F00D);
    // Illegal op 011 as store, odd address
    req(1'b0, 1'b1, 3'b011, 32'h13, 32'h1, 1'b0, 32'h7777_7777);
    chk("rw_novld", {31'h0, load_valid_w}, 32'h0);
    chk("ill_wen_n", {31'h0, ram_wen_n}, 32'h1);
    chk("ill_mis", {31'h0, misalign_m}, 32'h0);
    // HU as a store is illegal even when misaligned
    req(1'b0, 1'b1, 3'b101, 32'h21, 32'h1, 1'b0, 32'h0);
    chk("shu_wen_n", {31'h0, ram_wen_n}, 32'h1);
    chk("shu_mis", {31'h0, misalign_m}, 32'h0);
    idle(32'h0);
    chk("ill_no_err", {31'h0, err_sticky}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage load/store formatter between the core's M-stage outputs and the synchronous-read data RAM. Turns the byte address, RISC-V funct3 access size and store data into a word-aligned RAM address, byte enables and lane-shifted write data. It tracks each load across the one-cycle RAM read latency, then extracts and sign- or zero-extends the returned lane. It also flags misaligned accesses, suppresses them, and holds the first faulting address in a sticky error register.

## Interface
Parameters:
- none; datapath fixed at 32 bits.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- mem_r_m  input  1  M-stage load request
- mem_w_m  input  1  M-stage store request
- mem_op_m  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_m  input  32  byte address (ALU result)
- wdata_m  input  32  store data, right-justified
- err_clr  input  1  clears sticky error
- ram_addr  output  32  {addr_m[31:2], 2'b00}
- ram_wen_n  output  1  active-low RAM write enable
- ram_be  output  4  byte enables, bit i = byte lane i
- ram_din  output  32  lane-shifted store data
- ram_dout  input  32  RAM read data, valid one cycle after ram_addr
- load_valid_w  output  1  registered: load result valid this cycle
- load_data_w  output  32  extended load result
- misalign_m  output  1  combinational: current request misaligned
- err_sticky  output  1  registered: misalign seen since reset or clear
- err_addr  output  32  registered: address of first misaligned access

## Operation
- Misaligned: H/HU with addr_m[0]=1; W with addr_m[1:0]≠0. B/BU never misaligned. misalign_m = (mem_r_m|mem_w_m) & misaligned & legal op.
- Illegal op (011, 110, 111): no RAM write, no load tracked, no error.
- Store, legal and aligned: ram_wen_n=0.
  - SB: be = 0001<<addr[1:0]; din = {4{wdata[7:0]}}.
  - SH: be = 0011<<addr[1:0]; din = {2{wdata[15:0]}}.
  - SW: be = 1111; din = wdata.
- Otherwise: ram_wen_n=1, ram_be=0000, ram_din=wdata_m.
- mem_r_m and mem_w_m both high: store wins; load is dropped.
- BU and HU are load-only; as stores they are treated as illegal.
- Load, legal and aligned: registers pend_vld=1, pend_op=mem_op_m, pend_off=addr_m[1:0]; otherwise pend_vld=0.
- Load extraction, cycle after the load:
  - byte = ram_dout[8*off+:8]; half = ram_dout[16*off[1]+:16].
  - B sign-extends, BU zero-extends; H and HU likewise; W passes through.
- load_valid_w = pend_vld. load_data_w = 0 when pend_vld=0.
- Error capture, when misalign_m=1 and err_sticky=0: set err_sticky, err_addr ← addr_m.
- Later misaligns do not overwrite err_addr.
- err_clr=1 with no misalign that cycle: err_sticky ← 0; err_addr is kept.
- err_clr=1 and misalign_m=1 in the same cycle: the new capture wins (err_sticky=1, err_addr=new addr).

## Timing
- Reset (rst=0, asynchronous):
  - pend_vld=0, pend_op=0, pend_off=0, err_sticky=0, err_addr=0.
  - ram_wen_n is forced to 1 for as long as rst=0.
  - Consequently load_valid_w=0 and load_data_w=0.
- Store: single cycle. RAM samples ram_wen_n/ram_be/ram_din on the same edge the request is presented.
- Load: request in cycle N; load_valid_w and load_data_w valid in cycle N+1, combinational from ram_dout and the pend_* registers.
- Back-to-back loads: one result per cycle, no bubbles.
- Load followed by a store in the next cycle is legal; the store does not disturb the pending extraction.
- No stall input: the unit assumes the pipeline never freezes between N and N+1.
- Reset asserted between N and N+1 drops the pending load; no load_valid_w pulse follows.
- misalign_m is combinational, same cycle as the request. err_sticky and err_addr update on the next edge.

## Test plan
- SB at 0x103, wdata 0x000000AB: ram_addr 0x100, be 1000, din 0xABABABAB, wen_n 0. Then LBU at 0x103 with ram_dout 0xAB000000: next cycle load_data_w 0x000000AB; LB gives 0xFFFFFFAB.
- LH at 0x202 with ram_dout 0x8001_1234: load_data_w 0xFFFF8001. HU gives 0x00008001. LW at 0x200 passes 0x80011234.
- SW at 0x305: misalign_m=1, wen_n=1, be=0000. Next cycle err_sticky=1, err_addr 0x305. A later LH at 0x401 leaves err_addr at 0x305.
- err_clr together with LW at 0x502: err_sticky stays 1, err_addr becomes 0x502. err_clr alone next cycle: err_sticky=0.
- Four consecutive LW at 0x0, 0x4, 0x8, 0xC: load_valid_w high for four consecutive cycles, each result matching the prior cycle's ram_dout. Assert rst=0 after the first: load_valid_w drops immediately and wen_n=1.
- mem_r_m=1, mem_w_m=1, op 010, addr 0x10: store performed; no load_valid_w next cycle. Op 011 with mem_w_m: wen_n=1, no error.
